mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its issue/stall controller, placed in the E stage next to the ALU.
- Decodes the 4-bit XALUOp from the control decoder and sequences mult/multu/div/divu over a fixed latency.
- Owns the HI/LO registers and serves mthi/mtlo/mfhi/mflo.
- Generates the stall request the hazard unit uses to hold D while the unit is busy.

Parameters:
- MULT_LAT, 5, cycles busy is held after a mult/multu issue (>=1)
- DIV_LAT, 10, cycles busy is held after a div/divu issue (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- XALUOp  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu; other values mean none
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- E_valid  in  1  E-stage instruction is real; low means bubble or flush, so XALUOp is ignored
- D_md_use  in  1  D-stage instruction uses the unit (any XALUOp 1-8)
- start  out  1  combinational: E_valid & op in {1,2,7,8} & !busy
- busy  out  1  registered: operation in flight
- HI  out  32  HI register
- LO  out  32  LO register
- md_out  out  32  combinational: HI when op=5, LO when op=6, else 0
- md_stall  out  1  combinational: D_md_use & (start | busy)

Behaviour:
- Reset values: busy=0, HI=0, LO=0, counter=0, internal result registers=0. Reset mid-operation abandons the operation; the result is never committed.
- States: IDLE (busy=0) and RUN (busy=1). The 4-bit counter is sized for max(MULT_LAT, DIV_LAT).
- Issue (IDLE & start at edge T):
  - Compute the result from A/B at T and hold it in internal hi_n/lo_n.
  - counter <= LAT for the op; busy=1 from T+1.
- RUN: each edge decrements the counter. At the edge where counter==1: HI<=hi_n, LO<=lo_n, busy<=0. busy is therefore high for exactly LAT cycles, and the new HI/LO are visible in the cycle busy falls.
- mult: signed 64-bit product. multu: unsigned. HI=[63:32], LO=[31:0].
- div/divu:
  - LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - Signed 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divisor 0: the operation still takes DIV_LAT cycles, and HI/LO are left unchanged.
- mthi/mtlo (E_valid, !busy): HI<=A or LO<=A at the next edge, 1-cycle effect.
- Ops arriving while busy are ignored: no issue, no HI/LO write. The hazard unit guarantees they never arrive; the bench asserts this.
- mfhi/mflo return the current HI/LO, including a value written at the same edge as the op's arrival into E (no internal bypass needed beyond register output).
- Back-to-back: a new start is accepted in the first cycle with busy=0.

Optional Feature:
- MDU_MADD_EN defined:
  - Adds ops 9 madd, 10 maddu, 11 msub, 12 msubu, each with MULT_LAT latency.
  - {HI,LO} <= {HI,LO} ± product. The accumulator is sampled at commit, not at issue.
  - start and D_md_use decode cover 1-12.
- MDU_MADD_EN undefined: codes 9-12 are treated as none.

Decomposition:
- Package mdu_pkg holds:
  - the XALUOp code constants (0-12)
  - default latencies
  - function is_md_start(op)
- One sub-module, mdu_arith: combinational product/quotient/remainder producing hi_n/lo_n. Sequencing stays in mdu_ctrl.

Test Plan:
- Signed mult: A=3, B=0xFFFFFFFE, op=1 at edge 0 -> busy=1 in cycles 1-5; HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 5; busy=0.
- Divide: div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu A=7, B=0 -> HI/LO unchanged, busy still 10 cycles.
- Stall: op=7 issues with D_md_use=1 -> md_stall=1 on the start cycle and all 10 busy cycles, 0 afterwards. With D_md_use=0 -> md_stall=0 throughout.
- Move: mthi A=0x12345678, then mfhi next cycle -> md_out=0x12345678. mtlo while busy -> LO unchanged, assertion fires.
- Reset at busy cycle 3 of a multu -> busy=0, HI=LO=0 next cycle, no later commit.
- With MDU_MADD_EN: HI:LO=0:5, maddu A=2, B=3 -> LO=11, HI=0. With msub A=1, B=20 -> HI=0xFFFFFFFF, LO=0xFFFFFFF7.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and issue decode for the multiply/divide unit.
// MDU_MADD_EN adds the multiply-accumulate ops 9-12 to the issue decode.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int CNT_W        = 4;

  typedef enum logic {ST_IDLE, ST_RUN} mdu_state_e;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

  function automatic logic is_md_start(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient / remainder for the op being issued; wr low means "do not commit".
// MDU_MADD_EN adds the accumulate ops, which return the raw product plus an accumulate direction.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        wr_n,
  output acc_e        acc_n
);

  logic        signed_op;
  logic        mul_op;
  logic        div_op;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    signed_op = 1'b0;
    mul_op    = 1'b0;
    div_op    = 1'b0;
    acc_n     = ACC_NONE;
    case (op)
      OP_MULT:  begin mul_op = 1'b1; signed_op = 1'b1; end
      OP_MULTU: mul_op = 1'b1;
      OP_DIV:   begin div_op = 1'b1; signed_op = 1'b1; end
      OP_DIVU:  div_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin mul_op = 1'b1; signed_op = 1'b1; acc_n = ACC_ADD; end
      OP_MADDU: begin mul_op = 1'b1; acc_n = ACC_ADD; end
      OP_MSUB:  begin mul_op = 1'b1; signed_op = 1'b1; acc_n = ACC_SUB; end
      OP_MSUBU: begin mul_op = 1'b1; acc_n = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // Low 64 bits of an extended 64x64 product are correct for both signednesses.
  assign ext_a = {{32{signed_op & a[31]}}, a};
  assign ext_b = {{32{signed_op & b[31]}}, b};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes so 0x80000000 / -1 needs no special case.
  assign neg_a  = signed_op & a[31];
  assign neg_b  = signed_op & b[31];
  assign mag_a  = neg_a ? (32'd0 - a) : a;
  assign mag_b  = neg_b ? (32'd0 - b) : b;
  assign safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag  = mag_a / safe_b;
  assign r_mag  = mag_a % safe_b;
  assign quo    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
  assign rem    = neg_a ? (32'd0 - r_mag) : r_mag;

  assign hi_n = div_op ? rem : prod[63:32];
  assign lo_n = div_op ? quo : prod[31:0];
  assign wr_n = mul_op | (div_op & (b != 32'd0));

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, holds busy for MULT_LAT/DIV_LAT cycles, drives md_stall.
// MDU_MADD_EN enables madd/maddu/msub/msubu, accumulating into HI/LO at commit time.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  XALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        E_valid,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out,
  output logic        md_stall
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state;
  mdu_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] lat;
  logic             commit;
  logic             mv_hi;
  logic             mv_lo;

  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic        wr_n;
  acc_e        acc_n;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        wr_q;
  acc_e        acc_q;

  mdu_arith u_arith (
    .op    (XALUOp),
    .a     (A),
    .b     (B),
    .hi_n  (hi_n),
    .lo_n  (lo_n),
    .wr_n  (wr_n),
    .acc_n (acc_n)
  );

  assign busy = (state == ST_RUN);
  assign lat  = ((XALUOp == OP_DIV) || (XALUOp == OP_DIVU)) ? DIV_CNT : MULT_CNT;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        start = E_valid & is_md_start(XALUOp);
        if (start) begin
          state_nx = ST_RUN;
          cnt_nx   = lat;
        end
      end
      ST_RUN: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Moves only land while idle, so they never collide with a commit.
  assign mv_hi = E_valid & ~busy & (XALUOp == OP_MTHI);
  assign mv_lo = E_valid & ~busy & (XALUOp == OP_MTLO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      wr_q  <= 1'b0;
      acc_q <= ACC_NONE;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        wr_q  <= wr_n;
        acc_q <= acc_n;
      end
      if (commit && wr_q) begin
        case (acc_q)
          ACC_ADD: {HI, LO} <= {HI, LO} + {hi_q, lo_q};
          ACC_SUB: {HI, LO} <= {HI, LO} - {hi_q, lo_q};
          default: {HI, LO} <= {hi_q, lo_q};
        endcase
      end else if (mv_hi) begin
        HI <= A;
      end else if (mv_lo) begin
        LO <= A;
      end
    end
  end

  assign md_out   = (XALUOp == OP_MFHI) ? HI :
                    (XALUOp == OP_MFLO) ? LO : 32'd0;
  assign md_stall = D_md_use & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized bench for mdu_ctrl against a timestamp-based behavioural model of HI/LO and busy.
// Build with MDU_MADD_EN defined to also exercise the accumulate ops.
module tb_mdu_ctrl;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  XALUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        E_valid;
  logic        D_md_use;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;
  logic        md_stall;

  mdu_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .XALUOp   (XALUOp),
    .A        (A),
    .B        (B),
    .E_valid  (E_valid),
    .D_md_use (D_md_use),
    .start    (start),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .md_out   (md_out),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;
  int illegal;

  // Model: committed HI/LO, a pending result, and the edge number at which it lands.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  bit          p_wr;
  int          p_acc;
  longint      cyc;
  longint      done;
  bit          m_valid;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_is_start(input logic [3:0] op);
    if (op == 1 || op == 2 || op == 7 || op == 8) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= 9 && op <= 12) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit m_uses(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 1 && op <= 12);
`else
    return (op >= 1 && op <= 8);
`endif
  endfunction

  task automatic compare();
    bit mb;
    bit ms;
    logic [31:0] mo;
    if (!m_valid) return;
    mb = (cyc < done);
    ms = E_valid && m_is_start(XALUOp) && !mb;
    mo = (XALUOp == 4'd5) ? m_hi : (XALUOp == 4'd6) ? m_lo : 32'd0;
    chk32("busy", {31'd0, busy}, {31'd0, mb});
    chk32("start", {31'd0, start}, {31'd0, ms});
    chk32("md_stall", {31'd0, md_stall}, {31'd0, D_md_use && (ms || mb)});
    chk32("HI", HI, m_hi);
    chk32("LO", LO, m_lo);
    chk32("md_out", md_out, mo);
    if (E_valid && mb && m_uses(XALUOp)) illegal++;
  endtask

  task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint q;
    longint rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r = 64'd0;
    p_acc = 0;
    p_wr = 1'b1;
    case (op)
      4'd1: r = sa * sb;
      4'd2: r = ua * ub;
      4'd7, 4'd8: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin
          q  = (op == 4'd7) ? sa / sb : ua / ub;
          rm = (op == 4'd7) ? sa % sb : ua % ub;
          r  = {rm[31:0], q[31:0]};
        end
      end
      4'd9:  begin r = sa * sb; p_acc = 1; end
      4'd10: begin r = ua * ub; p_acc = 1; end
      4'd11: begin r = sa * sb; p_acc = 2; end
      4'd12: begin r = ua * ub; p_acc = 2; end
      default: ;
    endcase
    p_hi = r[63:32];
    p_lo = r[31:0];
    done = cyc + ((op == 4'd7 || op == 4'd8) ? DLAT : MLAT);
  endtask

  task automatic model_edge();
    bit was_busy;
    was_busy = (cyc < done);
    cyc++;
    if (reset) begin
      m_hi = 0; m_lo = 0; done = 0; p_wr = 1'b0; m_valid = 1'b1;
      return;
    end
    if (was_busy) begin
      if (cyc == done && p_wr) begin
        if (p_acc == 1)      {m_hi, m_lo} = {m_hi, m_lo} + {p_hi, p_lo};
        else if (p_acc == 2) {m_hi, m_lo} = {m_hi, m_lo} - {p_hi, p_lo};
        else                 {m_hi, m_lo} = {p_hi, p_lo};
      end
    end else if (E_valid) begin
      if (m_is_start(XALUOp)) model_issue(XALUOp, A, B);
      else if (XALUOp == 4'd3) m_hi = A;
      else if (XALUOp == 4'd4) m_lo = A;
    end
  endtask

  task automatic cyc_step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ev, input logic du);
    XALUOp = op; A = a; B = b; E_valid = ev; D_md_use = du;
  endtask

  // Steps until busy drops (bounded); returns busy cycles seen and md_stall-high cycles.
  task automatic run_busy(output int n, output int stalls);
    n = 0;
    stalls = 0;
    while (busy === 1'b1 && n < 60) begin
      stalls += (md_stall === 1'b1) ? 1 : 0;
      n++;
      cyc_step();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int st;
    logic [3:0] op;
    errs = 0; checks = 0; illegal = 0;
    cyc = 0; done = 0; m_valid = 1'b0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 1'b0; p_acc = 0;
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc_step();
    cyc_step();
    chk32("reset_busy", {31'd0, busy}, 32'd0);
    chk32("reset_HI", HI, 32'd0);
    chk32("reset_LO", LO, 32'd0);
    reset = 1'b0;

    // Signed mult 3 * -2
    drive(4'd1, 32'd3, 32'hFFFF_FFFE, 1'b1, 1'b0);
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_busy(n, st);
    chk32("mult_busy_cycles", n, 32'd5);
    chk32("mult_HI", HI, 32'hFFFF_FFFF);
    chk32("mult_LO", LO, 32'hFFFF_FFFA);

    // Signed divide -7 / 2 with a dependent instruction waiting in D
    drive(4'd7, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    #1 st = md_stall;
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    run_busy(n, illegal);
    st += illegal;
    illegal = 0;
    #1;
    chk32("div_busy_cycles", n, 32'd10);
    chk32("div_stall_cycles", st, 32'd11);
    chk32("div_stall_after", {31'd0, md_stall}, 32'd0);
    chk32("div_LO", LO, 32'hFFFF_FFFD);
    chk32("div_HI", HI, 32'hFFFF_FFFF);

    // divu by zero: full latency, HI/LO untouched, no stall without D use
    drive(4'd8, 32'd7, 32'd0, 1'b1, 1'b0);
    #1 st = md_stall;
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_busy(n, illegal);
    st += illegal;
    illegal = 0;
    chk32("divz_busy_cycles", n, 32'd10);
    chk32("divz_stall_cycles", st, 32'd0);
    chk32("divz_LO", LO, 32'hFFFF_FFFD);
    chk32("divz_HI", HI, 32'hFFFF_FFFF);

    // mthi then mfhi
    drive(4'd3, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    cyc_step();
    drive(4'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    #1 chk32("mfhi_out", md_out, 32'h1234_5678);
    cyc_step();

    // mtlo while busy must be dropped
    drive(4'd2, 32'd5, 32'd6, 1'b1, 1'b0);
    cyc_step();
    drive(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_busy(n, st);
    chk32("mtlo_busy_LO", LO, 32'd30);
    chk32("mtlo_busy_illegal", illegal, 32'd1);

    // Reset in the middle of a multu
    drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) cyc_step();
    reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    chk32("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk32("rst_mid_LO", LO, 32'd0);
    repeat (12) cyc_step();
    chk32("rst_late_HI", HI, 32'd0);
    chk32("rst_late_LO", LO, 32'd0);

`ifdef MDU_MADD_EN
    drive(4'd4, 32'd5, 32'd0, 1'b1, 1'b0);
    cyc_step();
    drive(4'd10, 32'd2, 32'd3, 1'b1, 1'b0);
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_busy(n, st);
    chk32("maddu_LO", LO, 32'd11);
    chk32("maddu_HI", HI, 32'd0);
    drive(4'd11, 32'd1, 32'd20, 1'b1, 1'b0);
    cyc_step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_busy(n, st);
    chk32("msub_HI", HI, 32'hFFFF_FFFF);
    chk32("msub_LO", LO, 32'hFFFF_FFF7);
`endif

    // Random traffic honouring the hazard unit's no-issue-while-busy guarantee
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 300 == 0);
      if (cyc < done) begin
        op = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(13, 15));
      end else begin
        op = 4'($urandom % 16);
      end
      drive(op, pick(), pick(), 1'($urandom % 4 != 0), 1'($urandom % 2));
      cyc_step();
    end
    reset = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (12) cyc_step();

    chk32("illegal_total", illegal, 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
